obi_axil_bridge_mo: RTL and testbench
=====================================

Name: obi_axil_bridge_mo

Overview:
Parametrised OBI-slave to AXI4-Lite-master bridge with multiple outstanding transactions, for the CV32E40P instruction and data ports. Successor to the single-outstanding bridge. Adds:
- configurable address/data width
- pipelined grants up to MAX_OUTST in flight
- in-order response guarantee across read/write direction changes
- AXI error reporting on OBI err

One instance per core port, between the core and the AXI interconnect.

Parameters:
ADDR_W, 32, address width of OBI and AXI.
DATA_W, 32, data width (32 or 64); strobe width is DATA_W/8.
MAX_OUTST, 2, maximum granted-but-unanswered OBI transactions (1..8).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
obi_req_i  in  1  OBI request.
obi_gnt_o  out  1  OBI grant (combinational).
obi_addr_i  in  ADDR_W  byte address, passed through unaligned.
obi_we_i  in  1  1 = write.
obi_be_i  in  DATA_W/8  byte enables.
obi_wdata_i  in  DATA_W  write data.
obi_rvalid_o  out  1  response valid, one pulse per granted request.
obi_rdata_o  out  DATA_W  read data; 0 for writes.
obi_err_o  out  1  response error, qualified by rvalid.
m_axi_awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  AW channel.
m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/DATA_W/8/1/1  W channel.
m_axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel.
m_axi_araddr/arvalid/arready  out/out/in  ADDR_W/1/1  AR channel.
m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  R channel.

Behaviour:
- Reset values (rst high at clock edge): awvalid, wvalid, arvalid, obi_rvalid_o, obi_err_o = 0; obi_rdata_o = 0; outstanding count = 0; issue slot empty. obi_gnt_o is forced to 0 while rst = 1.
- Issue slot: one register set (addr, we, be, wdata) with flags aw_pend, w_pend, ar_pend.
- Grant: obi_gnt_o = req & slot_empty & (cnt < MAX_OUTST) & (cnt == 0 | dir_q == obi_we_i).
  - "slot_empty" means all pend flags clear at the start of the cycle; no same-cycle refill.
- On grant:
  - Load the slot and set dir_q = obi_we_i.
  - Write: set aw_pend and w_pend. Read: set ar_pend.
  - Increment cnt.
- AXI valids are driven directly from the pend flags, so they first assert one cycle after the grant.
- AW and W are independent. Each flag clears on its own handshake, in either order or the same cycle. The slot is empty once both are clear.
- Valids are never dropped before their ready; payload is stable while valid.
- bready = rready = 1 permanently (OBI has no response backpressure).
- Responses:
  - On R handshake: next cycle obi_rvalid_o = 1, obi_rdata_o = rdata, obi_err_o = rresp[1].
  - On B handshake: next cycle obi_rvalid_o = 1, obi_rdata_o = 0, obi_err_o = bresp[1].
  - Responses are one-cycle pulses. Decrement cnt on each delivered response.
- Ordering: each AXI channel is in-order, and a direction switch is stalled until cnt == 0. This makes R/B interleave impossible, so OBI order is preserved.
- Simultaneous grant and response in one cycle: cnt unchanged.
- Unexpected B or R with cnt == 0: ignored, no OBI pulse.
- Minimum read latency (zero-wait slave): gnt at T0, arvalid at T1 (arready at T1), rvalid at T2, obi_rvalid_o at T3.
- Throughput: at most one grant every 2 cycles with a zero-wait slave, bounded by the single slot.
- Reset mid-operation: all state cleared immediately; in-flight AXI transactions are abandoned. The AXI slaves must share the same reset.
- cnt width: $clog2(MAX_OUTST+1).
- AXI protection and user signals are not present; the interconnect ties them off.

Decomposition:
- Package obi_axil_pkg holds:
  - axi_resp_e (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11)
  - dir_e (DIR_RD, DIR_WR)
  - issue-slot struct type, parametrised via localparams in the module
- No sub-module: the slot, counter and response register are each small and tightly coupled. Keep them in one module.

Test Plan:
1. Single read to 0x0000_0100, slave rdata 0xDEAD_BEEF, zero wait -> arvalid at T1, obi_rvalid_o at T3 with rdata 0xDEAD_BEEF, err 0.
2. Write 0x0000_0200, be 4'b0011, wdata 0x1234_5678; slave awready 3 cycles before wready -> wstrb 0011; exactly one obi_rvalid_o; no second grant until both handshakes complete.
3. MAX_OUTST = 2; slave stalls R for 10 cycles; core issues 3 reads -> 2 grants only; third granted the cycle after the first response.
4. Read outstanding, then write requested -> gnt held 0 until the read response is delivered and cnt = 0; the write is then granted.
5. Read with rresp = SLVERR, then write with bresp = DECERR -> obi_err_o = 1 on both pulses; rdata 0 on the write response.
6. Assert rst for 1 cycle while a write has AW done but W pending -> wvalid = 0, cnt = 0 the next cycle; a new read after reset completes normally.

Source files
------------

// File: rtl/obi_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obi_axil_pkg
// Description : Shared types for the OBI-to-AXI4-Lite multi-outstanding bridge.
//               Holds the AXI response encoding, the transfer direction and
//               the pending-flag set of the issue slot.
// Revision    : 1.0 - initial release
// ============================================================================
package obi_axil_pkg;

  // AXI4-Lite response codes (BRESP / RRESP)
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  // Direction of the transactions currently in flight
  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  // Outstanding AXI address/data phases of the single issue slot
  typedef struct packed {
    logic aw;
    logic w;
    logic ar;
  } slot_pend_t;

  // SLVERR and DECERR both map onto OBI err; OKAY/EXOKAY are successful.
  function automatic logic resp_is_err(input axi_resp_e resp);
    return (resp == SLVERR) || (resp == DECERR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_axil_bridge_mo.sv
`default_nettype none
// ============================================================================
// Module      : obi_axil_bridge_mo
// Description : OBI slave to AXI4-Lite master bridge with up to MAX_OUTST
//               granted-but-unanswered transactions. A single issue slot
//               feeds the AXI address/data channels; responses return to OBI
//               in order because a change of direction waits for the bridge
//               to drain completely.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   obi_req_i/gnt_o     : OBI request / combinational grant
//   obi_addr_i/we_i/be_i/wdata_i : OBI request payload
//   obi_rvalid_o/rdata_o/err_o   : OBI response (one pulse per grant)
//   m_axi_aw*, m_axi_w*, m_axi_b*: AXI4-Lite write channels
//   m_axi_ar*, m_axi_r*          : AXI4-Lite read channels
// ============================================================================
module obi_axil_bridge_mo
  import obi_axil_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  // OBI slave
  input  logic                  obi_req_i,
  output logic                  obi_gnt_o,
  input  logic [ADDR_W-1:0]     obi_addr_i,
  input  logic                  obi_we_i,
  input  logic [DATA_W/8-1:0]   obi_be_i,
  input  logic [DATA_W-1:0]     obi_wdata_i,
  output logic                  obi_rvalid_o,
  output logic [DATA_W-1:0]     obi_rdata_o,
  output logic                  obi_err_o,
  // AXI4-Lite master: write address
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // write data
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // write response
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // read address
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // read data
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  // Issue-slot payload; the direction is held separately in dir_q.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] be;
    logic [DATA_W-1:0] wdata;
  } slot_t;

  slot_t             slot_q, slot_d;
  slot_pend_t        pend_q, pend_d;
  dir_e              dir_q, dir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              slot_empty;
  logic              dir_ok;
  logic              gnt;
  logic              aw_hs, w_hs, ar_hs;
  logic [CNT_W-1:0]  in_flight;
  logic              r_acc, b_acc;
  dir_e              req_dir;

  assign req_dir    = obi_we_i ? DIR_WR : DIR_RD;
  assign slot_empty = ~(pend_q.aw | pend_q.w | pend_q.ar);
  // A direction switch only after every earlier response has been delivered.
  assign dir_ok     = (cnt_q == '0) || (dir_q == req_dir);
  assign gnt        = ~rst & obi_req_i & slot_empty & (cnt_q < CNT_MAX) & dir_ok;

  assign aw_hs = pend_q.aw & m_axi_awready;
  assign w_hs  = pend_q.w  & m_axi_wready;
  assign ar_hs = pend_q.ar & m_axi_arready;

  // cnt_q still includes a response that is being presented this cycle, so
  // exclude it when deciding whether an incoming AXI response is expected.
  assign in_flight = cnt_q - CNT_W'(rsp_valid_q);
  assign r_acc     = m_axi_rvalid & (in_flight != '0) & (dir_q == DIR_RD);
  assign b_acc     = m_axi_bvalid & (in_flight != '0) & (dir_q == DIR_WR);

  always_comb begin
    slot_d      = slot_q;
    pend_d      = pend_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;

    if (aw_hs) pend_d.aw = 1'b0;
    if (w_hs)  pend_d.w  = 1'b0;
    if (ar_hs) pend_d.ar = 1'b0;

    // Grant only happens with an empty slot, so it never collides with the
    // handshake clears above.
    if (gnt) begin
      slot_d.addr  = obi_addr_i;
      slot_d.be    = obi_be_i;
      slot_d.wdata = obi_wdata_i;
      dir_d        = req_dir;
      if (obi_we_i) begin
        pend_d.aw = 1'b1;
        pend_d.w  = 1'b1;
      end else begin
        pend_d.ar = 1'b1;
      end
    end

    if (r_acc) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = m_axi_rdata;
      rsp_err_d   = resp_is_err(axi_resp_e'(m_axi_rresp));
    end else if (b_acc) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = resp_is_err(axi_resp_e'(m_axi_bresp));
    end

    // A transaction leaves the count when its OBI response is delivered.
    case ({gnt, rsp_valid_q})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '0;
      pend_q      <= '0;
      dir_q       <= DIR_RD;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      pend_q      <= pend_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign obi_gnt_o     = gnt;
  assign obi_rvalid_o  = rsp_valid_q;
  assign obi_rdata_o   = rsp_data_q;
  assign obi_err_o     = rsp_err_q;

  assign m_axi_awaddr  = slot_q.addr;
  assign m_axi_awvalid = pend_q.aw;
  assign m_axi_wdata   = slot_q.wdata;
  assign m_axi_wstrb   = slot_q.be;
  assign m_axi_wvalid  = pend_q.w;
  assign m_axi_araddr  = slot_q.addr;
  assign m_axi_arvalid = pend_q.ar;

  // OBI cannot back-pressure responses, so AXI responses are always taken.
  assign m_axi_bready  = 1'b1;
  assign m_axi_rready  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_obi_axil_bridge_mo.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_axil_bridge_mo
// Description : Directed self-checking bench for obi_axil_bridge_mo with a
//               small reactive AXI4-Lite slave (configurable wait states).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_axil_bridge_mo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        obi_req_i = 1'b0;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i = '0;
  logic        obi_we_i = 1'b0;
  logic [3:0]  obi_be_i = '0;
  logic [31:0] obi_wdata_i = '0;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b1;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;

  obi_axil_bridge_mo dut (
    .clk(clk), .rst(rst),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- slave knobs ----------------
  int          r_wait  = 0;
  int          aw_wait = 0;
  int          w_wait  = 0;
  logic [31:0] rd_xor  = '0;
  logic [1:0]  rresp_k = 2'b00;
  logic [1:0]  bresp_k = 2'b00;

  // ---------------- reactive AXI slave ----------------
  // Handshakes are captured on the edge, new outputs are driven 1 time unit
  // later. Read data = araddr ^ rd_xor.
  logic [31:0] rq[$];
  int r_timer = 0, aw_cnt = 0, w_cnt = 0, aw_done = 0, w_done = 0;

  always @(posedge clk) begin : slave
    logic        rst_s, ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [31:0] ar_a;
    rst_s = rst;
    ar_hs = m_axi_arvalid & m_axi_arready;
    ar_a  = m_axi_araddr;
    r_hs  = m_axi_rvalid & m_axi_rready;
    aw_hs = m_axi_awvalid & m_axi_awready;
    w_hs  = m_axi_wvalid & m_axi_wready;
    b_hs  = m_axi_bvalid & m_axi_bready;
    #1;
    if (rst_s) begin
      rq.delete();
      r_timer = 0; aw_cnt = 0; w_cnt = 0; aw_done = 0; w_done = 0;
      m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
      m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    end else begin
      if (r_hs) begin
        if (rq.size() > 0) void'(rq.pop_front());
        m_axi_rvalid = 1'b0;
        r_timer = r_wait;
      end
      if (ar_hs) begin
        if (rq.size() == 0 && !m_axi_rvalid) r_timer = r_wait;
        rq.push_back(ar_a ^ rd_xor);
      end
      if (!m_axi_rvalid && rq.size() > 0) begin
        if (r_timer == 0) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = rq[0];
          m_axi_rresp  = rresp_k;
        end else begin
          r_timer--;
        end
      end
      if (aw_hs) aw_done++;
      if (w_hs)  w_done++;
      if (m_axi_awvalid && !aw_hs) begin
        m_axi_awready = (aw_cnt >= aw_wait);
        aw_cnt++;
      end else begin
        m_axi_awready = 1'b0;
        aw_cnt = 0;
      end
      if (m_axi_wvalid && !w_hs) begin
        m_axi_wready = (w_cnt >= w_wait);
        w_cnt++;
      end else begin
        m_axi_wready = 1'b0;
        w_cnt = 0;
      end
      if (b_hs) m_axi_bvalid = 1'b0;
      if (!m_axi_bvalid && aw_done > 0 && w_done > 0) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = bresp_k;
        aw_done--;
        w_done--;
      end
    end
  end

  // ---------------- OBI response monitor ----------------
  int          rsp_cyc[$];
  logic [31:0] rsp_dat[$];
  logic        rsp_err[$];

  always @(negedge clk) begin
    if (obi_rvalid_o) begin
      rsp_cyc.push_back(cyc);
      rsp_dat.push_back(obi_rdata_o);
      rsp_err.push_back(obi_err_o);
    end
  end

  // Presents one OBI request from the next posedge and holds it until granted.
  // Returns 1 time unit after the edge that follows the grant cycle.
  task automatic obi_issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, output int gc);
    gc = -1;
    @(posedge clk); #1;
    obi_req_i = 1'b1; obi_addr_i = a; obi_we_i = we; obi_be_i = be; obi_wdata_i = wd;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (obi_gnt_o) begin
        gc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (gc < 0) chk("gnt_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    obi_req_i = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    for (int k = 0; k < 100; k++) begin
      if (rsp_cyc.size() >= n) break;
      @(negedge clk);
    end
    chk(tag, 64'(rsp_cyc.size()), 64'(n));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int g, g2, g3, b;

    // ---- reset state, grant forced low under reset ----
    repeat (3) @(posedge clk);
    #1;
    obi_req_i = 1'b1; obi_we_i = 1'b0;
    @(negedge clk);
    chk("rst_gnt", obi_gnt_o, 0);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, obi_rvalid_o, obi_err_o}, 0);
    chk("rst_rdata", obi_rdata_o, 0);
    chk("rst_ready", {m_axi_bready, m_axi_rready}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b0; obi_req_i = 1'b0;

    // ---- 1: single zero-wait read ----
    rd_xor = 32'hDEAD_BFEF;  // 0x100 ^ 0xDEADBFEF = 0xDEADBEEF
    obi_issue(32'h0000_0100, 1'b0, 4'hF, 32'h0, g);
    @(negedge clk);
    chk("t1_arvalid", m_axi_arvalid, 1);
    chk("t1_araddr", m_axi_araddr, 32'h0000_0100);
    wait_rsp(1, "t1_rsp_cnt");
    chk("t1_rsp_cyc", 64'(rsp_cyc[0]), 64'(g + 3));
    chk("t1_rdata", rsp_dat[0], 32'hDEAD_BEEF);
    chk("t1_err", rsp_err[0], 0);

    // ---- 2: write, AW 3 cycles ahead of W, second write waits for the slot ----
    aw_wait = 0; w_wait = 3;
    b = rsp_cyc.size();
    obi_issue(32'h0000_0200, 1'b1, 4'b0011, 32'h1234_5678, g);
    @(negedge clk);
    chk("t2_awvalid", m_axi_awvalid, 1);
    chk("t2_awaddr", m_axi_awaddr, 32'h0000_0200);
    chk("t2_wstrb", m_axi_wstrb, 4'b0011);
    chk("t2_wdata", m_axi_wdata, 32'h1234_5678);
    obi_issue(32'h0000_0204, 1'b1, 4'b1111, 32'hCAFE_0001, g2);
    chk("t2_gnt2_cyc", 64'(g2), 64'(g + 5));
    wait_rsp(b + 2, "t2_rsp_cnt");
    chk("t2_rsp1_cyc", 64'(rsp_cyc[b]), 64'(g + 6));
    chk("t2_rsp1", {rsp_err[b], rsp_dat[b]}, 33'h0);
    repeat (6) @(negedge clk);
    chk("t2_rsp_total", 64'(rsp_cyc.size()), 64'(b + 2));

    // ---- 3: R stalled 10 cycles, three reads, MAX_OUTST = 2 ----
    w_wait = 0; r_wait = 10; rd_xor = 32'hA5A5_0000;
    b = rsp_cyc.size();
    obi_issue(32'h0000_0010, 1'b0, 4'hF, 32'h0, g);
    obi_issue(32'h0000_0020, 1'b0, 4'hF, 32'h0, g2);
    obi_issue(32'h0000_0030, 1'b0, 4'hF, 32'h0, g3);
    chk("t3_gnt2_cyc", 64'(g2), 64'(g + 2));
    chk("t3_gnt3_cyc", 64'(g3), 64'(g + 14));
    chk("t3_gnt3_after_rsp1", 64'(g3), 64'(rsp_cyc[b] + 1));
    wait_rsp(b + 3, "t3_rsp_cnt");
    chk("t3_rdata0", rsp_dat[b],     32'hA5A5_0010);
    chk("t3_rdata1", rsp_dat[b + 1], 32'hA5A5_0020);
    chk("t3_rdata2", rsp_dat[b + 2], 32'hA5A5_0030);

    // ---- 4: write behind an outstanding read waits for the drain ----
    r_wait = 4; rd_xor = 32'h0;
    b = rsp_cyc.size();
    obi_issue(32'h0000_0080, 1'b0, 4'hF, 32'h0, g);
    obi_issue(32'h0000_0084, 1'b1, 4'hF, 32'h5555_AAAA, g2);
    chk("t4_wr_gnt_cyc", 64'(g2), 64'(g + 8));
    chk("t4_wr_after_rsp", 64'(g2), 64'(rsp_cyc[b] + 1));
    wait_rsp(b + 2, "t4_rsp_cnt");
    chk("t4_rd_data", rsp_dat[b], 32'h0000_0080);
    chk("t4_wr_data", rsp_dat[b + 1], 32'h0);

    // ---- 5: error responses ----
    r_wait = 0; rresp_k = 2'b10; bresp_k = 2'b11; rd_xor = 32'h0;
    b = rsp_cyc.size();
    obi_issue(32'h0000_0040, 1'b0, 4'hF, 32'h0, g);
    obi_issue(32'h0000_0044, 1'b1, 4'hF, 32'hFFFF_FFFF, g2);
    wait_rsp(b + 2, "t5_rsp_cnt");
    chk("t5_rd_err", rsp_err[b], 1);
    chk("t5_rd_data", rsp_dat[b], 32'h0000_0040);
    chk("t5_wr_err", rsp_err[b + 1], 1);
    chk("t5_wr_data", rsp_dat[b + 1], 32'h0);
    rresp_k = 2'b00; bresp_k = 2'b00;

    // ---- 6: reset with AW done, W pending ----
    w_wait = 5;
    obi_issue(32'h0000_0300, 1'b1, 4'hF, 32'h0BAD_F00D, g);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_pre_aw_w", {m_axi_awvalid, m_axi_wvalid}, 2'b01);
    @(posedge clk); #1;
    rst = 1'b1;
    obi_req_i = 1'b1; obi_we_i = 1'b0;
    @(negedge clk);
    chk("t6_gnt_in_rst", obi_gnt_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; obi_req_i = 1'b0;
    @(negedge clk);
    chk("t6_post_aw_w", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
    chk("t6_cnt", 64'(dut.cnt_q), 64'd0);
    w_wait = 0; rd_xor = 32'h1111_0000;
    b = rsp_cyc.size();
    obi_issue(32'h0000_0500, 1'b0, 4'hF, 32'h0, g);
    wait_rsp(b + 1, "t6_rsp_cnt");
    chk("t6_rd", {rsp_err[b], rsp_dat[b]}, {1'b0, 32'h1111_0500});
    repeat (4) @(negedge clk);
    chk("t6_rsp_total", 64'(rsp_cyc.size()), 64'(b + 1));

    // ---- 7: unexpected B and R with nothing outstanding ----
    b = rsp_cyc.size();
    @(posedge clk); #1;
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0000_0BAD; m_axi_rresp = 2'b10;
    repeat (5) @(negedge clk);
    chk("t7_no_rsp", 64'(rsp_cyc.size()), 64'(b));
    chk("t7_cnt", 64'(dut.cnt_q), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
